next_pc_unit: RTL
=================

// Module: next_pc_unit
// PURPOSE
//  Parametrised next-PC generator for the RV32I core: owns the fetch PC register, steps it each
//  cycle and applies jal/jalr/B redirects from execute. Adds a registered PC, stall handling, a
//  one-entry pending-redirect buffer with valid/ready handshake, and a one-cycle flush pulse.
//  Sits between the execute stage (redirect source) and instruction memory (pc_o addresses it).
// PARAMETERS
//  PC_BITS   8      width of pc_o; targets are truncated to [PC_BITS-1:0]
//  RESET_PC  0      pc_o value after reset (PC_BITS wide)
//  PC_INC    4      sequential step added to pc_o per advancing cycle
// PORTS
//  clk         in   1        system clock, rising edge
//  rst_n       in   1        asynchronous active-low reset
//  stall_i     in   1        1 = hold pc_o (fetch stalled)
//  req_valid   in   1        execute presents a control-transfer instruction
//  req_ready   out  1        unit accepts the request this cycle
//  opcode      in   7        instruction opcode
//  s           in   32       base: current PC for jal/B, rs1 value for jalr
//  imme_in     in   32       sign-extended immediate
//  br_taken    in   1        branch condition result (used only for B)
//  pc_o        out  PC_BITS  fetch PC (registered)
//  flush_o     out  1        1-cycle pulse: pc_o just took a redirect target
//  misalign_o  out  1        1-cycle pulse: accepted target misaligned (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, rst_n=0): pc_o=RESET_PC, flush_o=0, misalign_o=0, state=RUN, pending cleared.
//  - Target: jal 1101111 and B 1100011 (br_taken=1): s+imme_in; jalr 1100111: (s+imme_in)&~1.
//    32-bit add, carry dropped, then truncated to PC_BITS. Other opcodes / B not taken: no redirect.
//  - Handshake: request accepted when req_valid & req_ready. req_ready = (state==RUN).
//    Non-redirecting accepted requests have no effect.
//  - RUN, accepted redirect, stall_i=0: next edge pc_o<=target, flush_o=1 for that cycle.
//  - RUN, accepted redirect, stall_i=1: target stored in pending reg, go HOLD; pc_o unchanged.
//  - RUN, no redirect: stall_i=0 -> pc_o<=pc_o+PC_INC (mod 2^PC_BITS, wraps); stall_i=1 -> hold.
//  - HOLD: req_ready=0; pc_o held while stall_i=1; first cycle with stall_i=0 -> pc_o<=pending,
//    flush_o=1, state RUN. Sequential increment never occurs in the same edge as a redirect.
//  - Redirect always wins over the sequential increment; flush_o/misalign_o never stay high >1 cycle
//    for a single request.
//  - Reset asserted in HOLD discards the pending target; pc_o returns to RESET_PC.
//  - Latency: accepted request -> pc_o updated at next unstalled edge (1 cycle if unstalled).
// CONFIGURATION
//  NPC_MISALIGN_CHK_EN defined: an accepted redirect whose truncated target has bits[1:0]!=0
//   is suppressed (no pc load, no HOLD entry, flush_o=0); misalign_o pulses 1 cycle at the edge
//   where the load would have occurred; pc_o continues per stall_i.
//  Not defined: no alignment check; every target loads as is; misalign_o tied to 0.
// TESTING
//  1 reset: rst_n=0 mid-run -> pc_o=0 immediately; release, 3 unstalled cycles -> 4,8,12.
//  2 jal s=0x10 imm=0x20, stall_i=0 -> next cycle pc_o=0x30, flush_o=1 one cycle, then 0x34.
//  3 jalr s=0x41 imm=0x2 -> pc_o=0x42; B br_taken=0 -> no redirect, pc_o+4, flush_o=0.
//  4 B taken s=0x80 imm=0x40 with stall_i=1 for 3 cycles -> req_ready=0, pc_o held; stall drop
//    -> pc_o=0xC0, flush_o=1; reset during hold instead -> pc_o=0, no flush.
//  5 wrap: PC_BITS=8, pc_o=0xFC unstalled -> 0x00; jal s=0xF0 imm=0x20 -> pc_o=0x10.
//  6 jal target 0x32 -> with NPC_MISALIGN_CHK_EN: misalign_o=1, pc_o steps +4; without: pc_o=0x32.

Source files
------------

// File: rtl/next_pc_unit_if.sv
// Redirect request bus between the execute stage (master) and the next-PC unit (slave).
interface next_pc_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  opcode;
    logic [31:0] s;
    logic [31:0] imme_in;
    logic        br_taken;

    modport master (
        output req_valid, opcode, s, imme_in, br_taken,
        input  req_ready
    );

    modport slave (
        input  req_valid, opcode, s, imme_in, br_taken,
        output req_ready
    );
endinterface

// File: rtl/next_pc_unit.sv
// Fetch PC generator: sequential stepping, jal/jalr/B redirects, stall-aware pending redirect.
// Optional NPC_MISALIGN_CHK_EN suppresses redirects to targets with bits[1:0] != 0.
module next_pc_unit #(
    parameter int unsigned         PC_BITS  = 8,
    parameter logic [PC_BITS-1:0]  RESET_PC = '0,
    parameter int unsigned         PC_INC   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_i,
    next_pc_unit_if.slave       req,
    output logic [PC_BITS-1:0]  pc_o,
    output logic                flush_o,
    output logic                misalign_o
);
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic {RUN, HOLD} state_t;

    state_t               state_q, state_d;
    logic [PC_BITS-1:0]   pc_q, pc_d;
    logic [PC_BITS-1:0]   pend_q, pend_d;
    logic                 flush_q, flush_d;
    logic                 misalign_q, misalign_d;

    logic [31:0]          sum_full;
    logic [31:0]          target_full;
    logic [PC_BITS-1:0]   target;
    logic                 is_redirect;
    logic                 accept;
    logic                 misaligned;
    logic                 unused_sum;

    // Target computation: 32-bit add, jalr clears bit 0, then truncate to PC width.
    always_comb begin
        sum_full    = req.s + req.imme_in;
        target_full = (req.opcode == OP_JALR) ? (sum_full & ~32'h1) : sum_full;
        target      = PC_BITS'(target_full);
        is_redirect = (req.opcode == OP_JAL) || (req.opcode == OP_JALR) ||
                      ((req.opcode == OP_BRANCH) && req.br_taken);
        accept      = req.req_valid && (state_q == RUN);
`ifdef NPC_MISALIGN_CHK_EN
        misaligned  = (target[1:0] != 2'b00);
`else
        misaligned  = 1'b0;
`endif
    end

    assign unused_sum    = ^target_full;
    assign req.req_ready = (state_q == RUN);

    // Next-state and next-PC selection; redirect always beats the sequential step.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        flush_d    = 1'b0;
        misalign_d = 1'b0;
        unique case (state_q)
            RUN: begin
                if (accept && is_redirect && misaligned) begin
                    misalign_d = 1'b1;
                    if (!stall_i) pc_d = pc_q + PC_BITS'(PC_INC);
                end else if (accept && is_redirect) begin
                    if (!stall_i) begin
                        pc_d    = target;
                        flush_d = 1'b1;
                    end else begin
                        pend_d  = target;
                        state_d = HOLD;
                    end
                end else if (!stall_i) begin
                    pc_d = pc_q + PC_BITS'(PC_INC);
                end
            end
            HOLD: begin
                if (!stall_i) begin
                    pc_d    = pend_q;
                    flush_d = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            pend_q     <= '0;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            flush_q    <= flush_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_o       = pc_q;
    assign flush_o    = flush_q;
    assign misalign_o = misalign_q;
endmodule
